// File: rtl/dest_track.sv
// Destination tracking through the DX/XM/MWB slots, load-use stall
// detection and a saturating stall-cycle counter.
module dest_track #(
   parameter int unsigned REG_W = 3,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic             id_rw,
   input  logic [REG_W-1:0] id_dr,
   input  logic             id_is_load,
   input  logic [REG_W-1:0] id_rs,
   input  logic             id_rs_used,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rt_used,
   input  logic             flush,
   input  logic             mem_stall,
   output logic             stall_id,
   output logic             dx_rw,
   output logic [REG_W-1:0] dx_dr,
   output logic             dx_ld,
   output logic             xm_rw,
   output logic [REG_W-1:0] xm_dr,
   output logic             xm_ld,
   output logic             mwb_rw,
   output logic [REG_W-1:0] mwb_dr,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             r_dx_rw, r_dx_ld, r_xm_rw, r_xm_ld, r_mwb_rw;
   logic [REG_W-1:0] r_dx_dr, r_xm_dr, r_mwb_dr;
   logic [CNT_W-1:0] r_cnt;

   logic w_hit_rs, w_hit_rt, w_stall, w_bubble, w_cnt_max;

   // Load in DX whose result a source operand of the decode instruction needs
   assign w_hit_rs  = id_rs_used & (id_rs == r_dx_dr);
   assign w_hit_rt  = id_rt_used & (id_rt == r_dx_dr);
   assign w_stall   = id_valid & ~flush & r_dx_ld & r_dx_rw & (w_hit_rs | w_hit_rt);
   assign w_bubble  = flush | w_stall | ~id_valid;
   assign w_cnt_max = &r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dx_rw  <= 1'b0;
         r_dx_dr  <= REG_W'(0);
         r_dx_ld  <= 1'b0;
         r_xm_rw  <= 1'b0;
         r_xm_dr  <= REG_W'(0);
         r_xm_ld  <= 1'b0;
         r_mwb_rw <= 1'b0;
         r_mwb_dr <= REG_W'(0);
         r_cnt    <= CNT_W'(0);
      end else if (!mem_stall) begin
         r_mwb_rw <= r_xm_rw;
         r_mwb_dr <= r_xm_dr;
         r_xm_rw  <= r_dx_rw;
         r_xm_dr  <= r_dx_dr;
         r_xm_ld  <= r_dx_ld;
         if (w_bubble) begin
            r_dx_rw <= 1'b0;
            r_dx_dr <= REG_W'(0);
            r_dx_ld <= 1'b0;
         end else begin
            r_dx_rw <= id_rw;
            r_dx_dr <= id_rw ? id_dr : REG_W'(0);
            r_dx_ld <= id_is_load & id_rw;
         end
         if (w_stall && !w_cnt_max)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign stall_id  = w_stall;
   assign dx_rw     = r_dx_rw;
   assign dx_dr     = r_dx_dr;
   assign dx_ld     = r_dx_ld;
   assign xm_rw     = r_xm_rw;
   assign xm_dr     = r_xm_dr;
   assign xm_ld     = r_xm_ld;
   assign mwb_rw    = r_mwb_rw;
   assign mwb_dr    = r_mwb_dr;
   assign stall_cnt = r_cnt;

endmodule
